// File: rtl/sync_counter_pkg.sv
// Shared constants for the sync_counter family of blocks.
package sync_counter_pkg;

    // Direction select values for up_dn
    localparam logic CNT_DOWN  = 1'b0;
    localparam logic CNT_UP    = 1'b1;

    // End-of-range behaviour values for sat_mode
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/sync_counter_mod.sv
// Parametrised modulo-N synchronous counter: up/down, parallel load,
// saturate-or-wrap, with carry-in/carry-out for single-clock cascading.
module sync_counter_mod
    import sync_counter_pkg::*;
#(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = 16,
    parameter longint RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             count,
    input  logic             cin,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             cout,
    output logic             wrap,
    output logic             load_err
);

    // Reject illegal parameter sets at elaboration
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("sync_counter_mod: WIDTH must be 1..32");
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("sync_counter_mod: MODULUS must be 2..2**WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
            $error("sync_counter_mod: RESET_VAL must be below MODULUS");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);
    // MAX_VAL widened by one bit so compares never overflow at MODULUS == 2**WIDTH
    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_VAL};

    logic             en;
    logic [WIDTH:0]   q_inc;
    logic [WIDTH-1:0] q_dec;
    logic             at_top;
    logic             at_bot;
    logic             load_oor;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    assign en       = count & cin;
    assign q_inc    = {1'b0, q} + (WIDTH+1)'(1);
    assign q_dec    = q - WIDTH'(1);
    // Incremented value past MAX_VAL means q sits at the top of the range
    assign at_top   = (q_inc > MAX_EXT);
    assign at_bot   = (q == '0);
    assign load_oor = ({1'b0, load_val} > MAX_EXT);

    // Next-state selection: load > enabled count > hold (clear handled in the register)
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (load) begin
            if (load_oor) begin
                q_nxt   = MAX_VAL;
                err_nxt = 1'b1;
            end else begin
                q_nxt   = load_val;
            end
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                if (!at_top) begin
                    q_nxt = q_inc[WIDTH-1:0];
                end else if (sat_mode == MODE_WRAP) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    q_nxt = q_dec;
                end else if (sat_mode == MODE_WRAP) begin
                    q_nxt    = MAX_VAL;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    // Count register and one-cycle status pulses; clear suppresses both pulses
    always_ff @(posedge clk) begin
        if (clear) begin
            q        <= RST_Q;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_nxt;
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

    // Terminal count depends on direction; carry only propagates in wrap mode
    assign tc   = (up_dn == CNT_UP) ? (q == MAX_VAL) : at_bot;
    assign cout = tc & en & (sat_mode == MODE_WRAP);

endmodule

// File: tb/tb_sync_counter_mod.sv
// Self-checking bench: directed table, two-digit cascade, randomized vs. model.
module tb_sync_counter_mod;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       clear, count, up_dn, sat_mode, load;
    logic [3:0] load_val;
    logic [3:0] u_q, t_q;
    logic       u_tc, u_cout, u_wrap, u_err;
    logic       t_tc, t_cout, t_wrap, t_err;
    logic       t_load;
    logic [3:0] t_lv;
    logic       u_cin;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) units (
        .clk(clk), .clear(clear), .count(count), .cin(u_cin), .up_dn(up_dn),
        .sat_mode(sat_mode), .load(load), .load_val(load_val),
        .q(u_q), .tc(u_tc), .cout(u_cout), .wrap(u_wrap), .load_err(u_err)
    );

    sync_counter_mod #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) tens (
        .clk(clk), .clear(clear), .count(count), .cin(u_cout), .up_dn(up_dn),
        .sat_mode(sat_mode), .load(t_load), .load_val(t_lv),
        .q(t_q), .tc(t_tc), .cout(t_cout), .wrap(t_wrap), .load_err(t_err)
    );

    typedef struct {
        bit cl, cnt, up, sat, ld;
        int lv;
        int q;
        bit w, e;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input bit cl, cnt, up, sat, ld, input int lv, q, input bit w, e);
        vec_t v;
        v = '{cl, cnt, up, sat, ld, lv, q, w, e};
        tbl.push_back(v);
    endtask

    // Modulo-M step: wrap uses modular arithmetic, saturate clamps to [0, M-1]
    task automatic mstep(input int v, input bit en, up, sat, output int nv, output bit w);
        nv = v;
        w  = 1'b0;
        if (en) begin
            if (sat) begin
                nv = up ? ((v + 1 > M - 1) ? M - 1 : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
            end else begin
                nv = (v + (up ? 1 : M - 1)) % M;
                w  = up ? (v == M - 1) : (v == 0);
            end
        end
    endtask

    task automatic drive(input bit cl, cnt, up, sat, ld, input int lv);
        clear    = cl;
        count    = cnt;
        up_dn    = up;
        sat_mode = sat;
        load     = ld;
        load_val = 4'(lv);
    endtask

    initial begin
        int u, t, nu, nt;
        bit uw, ue, tw, utc, ucout, ten, ttc;
        bit exp_tc;

        u_cin  = 1'b1;
        t_load = 1'b0;
        t_lv   = 4'd0;
        drive(1, 0, 1, 0, 0, 0);

        // ---- directed table ----
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) add(0, 1, 1, 0, 0, 0, (i + 1) % 10, i == 9, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) add(0, 1, 1, 1, 0, 0, (i + 1 > 9) ? 9 : i + 1, 0, 0);
        add(0, 0, 1, 0, 1, 2, 2, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 9, 1, 0);
        add(0, 1, 0, 0, 0, 0, 8, 0, 0);
        add(0, 0, 1, 0, 1, 7, 7, 0, 0);
        add(0, 0, 1, 0, 1, 12, 9, 0, 1);
        add(0, 0, 1, 0, 0, 0, 9, 0, 0);
        add(0, 1, 1, 0, 1, 3, 3, 0, 0);
        add(0, 0, 1, 0, 1, 15, 9, 0, 1);
        add(0, 1, 1, 0, 1, 5, 5, 0, 0);
        add(1, 1, 1, 0, 1, 12, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 9, 1, 0);

        foreach (tbl[k]) begin
            drive(tbl[k].cl, tbl[k].cnt, tbl[k].up, tbl[k].sat, tbl[k].ld, tbl[k].lv);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_q", k), u_q, tbl[k].q);
            chk($sformatf("tbl%0d_wrap", k), u_wrap, tbl[k].w);
            chk($sformatf("tbl%0d_lerr", k), u_err, tbl[k].e);
            exp_tc = tbl[k].up ? (tbl[k].q == 9) : (tbl[k].q == 0);
            chk($sformatf("tbl%0d_tc", k), u_tc, exp_tc);
            chk($sformatf("tbl%0d_cout", k), u_cout, exp_tc & tbl[k].cnt & ~tbl[k].sat);
        end

        // ---- two-digit cascade: 0..99 then roll to 00 on one edge ----
        drive(1, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("casc_clr_u", u_q, 0);
        chk("casc_clr_t", t_q, 0);
        drive(0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("casc%0d_u", i), u_q, i % 10);
            chk($sformatf("casc%0d_t", i), t_q, (i / 10) % 10);
            chk($sformatf("casc%0d_uwrap", i), u_wrap, (i % 10) == 0);
            chk($sformatf("casc%0d_twrap", i), t_wrap, i == 100);
        end

        // ---- randomized against the reference model ----
        u = 0; t = 0;
        for (int n = 0; n < 600; n++) begin
            drive((n == 0) || ($urandom_range(0, 31) == 0), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15));
            #1;
            utc   = up_dn ? (u == M - 1) : (u == 0);
            ucout = utc & count & ~sat_mode;
            ten   = count & ucout;
            ttc   = up_dn ? (t == M - 1) : (t == 0);
            if (n > 0) begin
                chk($sformatf("rnd%0d_tc", n), u_tc, utc);
                chk($sformatf("rnd%0d_cout", n), u_cout, ucout);
                chk($sformatf("rnd%0d_tcout", n), t_cout, ttc & ten & ~sat_mode);
            end
            if (clear) begin
                nu = 0; nt = 0; uw = 0; ue = 0; tw = 0;
            end else begin
                if (load) begin
                    nu = (load_val < M) ? int'(load_val) : M - 1;
                    ue = (load_val >= M);
                    uw = 0;
                end else begin
                    mstep(u, count, up_dn, sat_mode, nu, uw);
                    ue = 0;
                end
                mstep(t, ten, up_dn, sat_mode, nt, tw);
            end
            u = nu; t = nt;
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_uq", n), u_q, u);
            chk($sformatf("rnd%0d_uwrap", n), u_wrap, uw);
            chk($sformatf("rnd%0d_uerr", n), u_err, ue);
            chk($sformatf("rnd%0d_tq", n), t_q, t);
            chk($sformatf("rnd%0d_twrap", n), t_wrap, tw);
            chk($sformatf("rnd%0d_terr", n), t_err, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_counter_mod.md
Name: sync_counter_mod

Overview:
- Parametrised synchronous counter; next-generation, generalised form of the team's 4-bit SynchCount.
- Adds configurable width and modulus, up/down direction, parallel load, and a saturate/wrap mode.
- Adds a carry-in/carry-out chain so multi-digit counters (e.g. BCD) cascade on one clock.
- Used standalone or as a digit cell in cascaded display/timer counters.

Parameters:
- WIDTH, 4, counter width in bits; legal 1..32.
- MODULUS, 16, count range is 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH.
- RESET_VAL, 0, value of q after clear; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  reset, synchronous, active-high; sampled on rising edge of clk.
- count  input  1  count enable.
- cin  input  1  cascade carry-in; tie 1 when unused. Effective enable en = count & cin.
- up_dn  input  1  1 = count up, 0 = count down.
- sat_mode  input  1  1 = saturate at end of range, 0 = wrap.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count: q==MODULUS-1 when up_dn=1; q==0 when up_dn=0.
- cout  output  1  combinational cascade carry: tc & en & ~sat_mode.
- wrap  output  1  registered pulse, high for exactly one cycle after a wrap occurred.
- load_err  output  1  registered pulse, high one cycle after a load with load_val >= MODULUS.

Behaviour:
- Reset values: q=RESET_VAL, wrap=0, load_err=0. Reset occurs only on a clk edge with clear=1.
- Per-edge priority: clear > load > en > hold.
- load=1:
  - q <= load_val if load_val < MODULUS.
  - Otherwise q <= MODULUS-1 and load_err <= 1.
  - count/cin are ignored that cycle; wrap <= 0.
- en=1, up_dn=1:
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1, sat_mode=0: q <= 0, wrap <= 1.
  - q == MODULUS-1, sat_mode=1: q holds, wrap <= 0.
- en=1, up_dn=0:
  - q > 0: q <= q-1.
  - q == 0, sat_mode=0: q <= MODULUS-1, wrap <= 1.
  - q == 0, sat_mode=1: q holds, wrap <= 0.
- en=0 and no load: q holds.
- wrap and load_err are 0 on every edge that does not set them; they are never sticky.
- Latency: q changes 1 cycle after a qualifying edge. tc and cout follow q and inputs combinationally, with zero latency.
- Cascade: a digit's cout drives the next digit's cin. All digits share count, up_dn, sat_mode and clk, so the chain advances on the same edge with no ripple delay in q.
- Arithmetic: next-value computed at WIDTH+1 bits, then compared against MODULUS-1. No overflow of WIDTH is possible when MODULUS == 2**WIDTH.
- Changing direction mid-count takes effect on the next enabled edge; no extra state.
- clear asserted together with load or en: clear wins, and no wrap or load_err pulse is generated.
- Illegal parameters (MODULUS out of range, RESET_VAL >= MODULUS): elaboration-time error via generate-time check.

Decomposition:
- Shared package sync_counter_pkg holds:
  - Direction constants CNT_DOWN=1'b0, CNT_UP=1'b1.
  - Mode constants MODE_WRAP=1'b0, MODE_SAT=1'b1.
- Local constant MAX_VAL = MODULUS-1 stays in the module.
- No sub-module is natural: single always block for q/wrap/load_err plus continuous assigns for tc/cout.
- A cascade wrapper (sync_counter_chain) is a separate future block, not part of this one.

Test Plan:
- WIDTH=4, MODULUS=10, clear=1 for 2 cycles, then count=1, cin=1, up_dn=1, sat_mode=0 for 12 cycles -> q = 0,1,...,9,0,1,2. wrap high only on the cycle q=0 after 9. tc high only while q=9.
- Same config, sat_mode=1, 12 up-counts from 0 -> q reaches 9 and holds. wrap stays 0. cout stays 0.
- up_dn=0 from q=2, 4 enabled cycles, sat_mode=0 -> q = 1,0,9,8. wrap pulses once, after 0->9.
- load=1 with load_val=7 -> q=7 next cycle. Then load_val=12 -> q=9 and load_err pulses one cycle. Assert load with count=1 -> load wins.
- Two instances cascaded (units.cout -> tens.cin), MODULUS=10, count 0..99 then one more -> tens:units = 9:9 then 0:0. Tens wraps on the same edge as units.
- Mid-run clear=1 with count=1 and load=1 at q=5 -> q=RESET_VAL (0) next edge. No wrap or load_err pulse.
